// File: rtl/fbcpu_pkg.sv
// Shared types and constants for the FBCPU boot loader and its program RAM.
package fbcpu_pkg;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_HI,
        ST_LO,
        ST_RUN,
        ST_ERR
    } ld_state_e;

    localparam int unsigned MAX_WORDS    = 64;
    localparam int unsigned CNT_W        = 7;
    localparam logic [7:0]  HI_RSVD_MASK = 8'hFC;

endpackage

// File: rtl/fbcpu_ram.sv
// Program/data RAM: one synchronous write port, one registered read-first read port.
module fbcpu_ram #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Array is intentionally never reset so a reload only overwrites what it sends.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read samples the array before this edge's write lands, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fbcpu_boot_loader.sv
// Loads the FBCPU program RAM from a byte stream, holds the core in reset while
// loading, then hands the RAM port to the core.
module fbcpu_boot_loader
    import fbcpu_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 6,
    parameter int unsigned DATA_WIDTH    = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    input  logic [ADDRESS_WIDTH-1:0] MAR,
    input  logic                     RAMWr,
    input  logic [DATA_WIDTH-1:0]    MDRIn,
    output logic [DATA_WIDTH-1:0]    MDROut,
    output logic                     cpu_rst,
    output logic                     load_done,
    output logic                     load_err
);

    localparam int unsigned DEPTH      = 2 ** ADDRESS_WIDTH;
    localparam int unsigned WORD_LIMIT = (DEPTH < MAX_WORDS) ? DEPTH : MAX_WORDS;

    ld_state_e                state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [1:0]               hi_q, hi_d;

    logic in_ready_q, in_ready_d;
    logic cpu_rst_q, cpu_rst_d;
    logic load_done_q, load_done_d;
    logic load_err_q, load_err_d;

    logic                     xfer_c;
    logic                     ld_we_c;
    logic                     ram_we_c;
    logic [ADDRESS_WIDTH-1:0] ram_waddr_c;
    logic [DATA_WIDTH-1:0]    ram_wdata_c;

    assign xfer_c = in_valid && in_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HDR;
            addr_q      <= '0;
            cnt_q       <= '0;
            hi_q        <= '0;
            in_ready_q  <= 1'b0;
            cpu_rst_q   <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            in_ready_q  <= in_ready_d;
            cpu_rst_q   <= cpu_rst_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    // Stream parser; outputs are decoded from the next state so they register with it.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        ld_we_c     = 1'b0;

        unique case (state_q)
            ST_HDR: begin
                if (xfer_c) begin
                    if ((in_data != 8'd0) && (in_data <= 8'(WORD_LIMIT))) begin
                        cnt_d   = CNT_W'(in_data);
                        addr_d  = '0;
                        state_d = ST_HI;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_HI: begin
                if (xfer_c) begin
                    if ((in_data & HI_RSVD_MASK) != 8'd0) begin
                        state_d = ST_ERR;
                    end else begin
                        hi_d    = in_data[1:0];
                        state_d = ST_LO;
                    end
                end
            end
            ST_LO: begin
                if (xfer_c) begin
                    ld_we_c = 1'b1;
                    addr_d  = addr_q + ADDRESS_WIDTH'(1);
                    if (CNT_W'(addr_q) == (cnt_q - CNT_W'(1))) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_HI;
                    end
                end
            end
            ST_RUN: state_d = ST_RUN;
            ST_ERR: state_d = ST_ERR;
            default: state_d = ST_HDR;
        endcase

        in_ready_d  = (state_d == ST_HDR) || (state_d == ST_HI) || (state_d == ST_LO);
        cpu_rst_d   = (state_d != ST_RUN);
        load_done_d = (state_d == ST_RUN);
        load_err_d  = (state_d == ST_ERR);
    end

    // Write port belongs to the loader until RUN, then to the core.
    always_comb begin
        ram_we_c    = 1'b0;
        ram_waddr_c = addr_q;
        ram_wdata_c = DATA_WIDTH'({hi_q, in_data});
        if (!rst) begin
            if (state_q == ST_RUN) begin
                ram_we_c    = RAMWr;
                ram_waddr_c = MAR;
                ram_wdata_c = MDRIn;
            end else begin
                ram_we_c    = ld_we_c;
            end
        end
    end

    fbcpu_ram #(
        .ADDR_W (ADDRESS_WIDTH),
        .DATA_W (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we_c),
        .waddr_i (ram_waddr_c),
        .wdata_i (ram_wdata_c),
        .raddr_i (MAR),
        .rdata_o (MDROut)
    );

    assign in_ready  = in_ready_q;
    assign cpu_rst   = cpu_rst_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_fbcpu_boot_loader.sv
// Randomized self-checking bench for fbcpu_boot_loader against an array model of the RAM.
module tb_fbcpu_boot_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [5:0] MAR;
    logic       RAMWr;
    logic [9:0] MDRIn;
    logic [9:0] MDROut;
    logic       cpu_rst;
    logic       load_done;
    logic       load_err;

    int checks   = 0;
    int failures = 0;

    logic [9:0] ref_mem   [64];
    bit         ref_known [64];
    logic [9:0] ld_buf    [64];

    fbcpu_boot_loader #(.ADDRESS_WIDTH(6), .DATA_WIDTH(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .MAR       (MAR),
        .RAMWr     (RAMWr),
        .MDRIn     (MDRIn),
        .MDROut    (MDROut),
        .cpu_rst   (cpu_rst),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic core_noise();
        MAR   = 6'($urandom);
        RAMWr = 1'($urandom);
        MDRIn = 10'($urandom);
    endtask

    // Offers one byte and waits (bounded) until it is accepted.
    task automatic send_byte(input logic [7:0] b, input bit jitter);
        int cyc = 0;
        if (jitter) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                core_noise();
                step();
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        core_noise();
        while (in_ready !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready=%b required 1 for byte %h", in_ready, b);
        end
        step();
        in_valid = 1'b0;
        RAMWr    = 1'b0;
    endtask

    task automatic load_prog(input int n, input bit jitter);
        send_byte(8'(n), jitter);
        for (int i = 0; i < n; i++) begin
            send_byte({6'b0, ld_buf[i][9:8]}, jitter);
            if (i == n - 1) begin
                checks++;
                if (load_done !== 1'b0 || cpu_rst !== 1'b1) begin
                    failures++;
                    $display("FAIL early_done: load_done=%b cpu_rst=%b required 0/1", load_done, cpu_rst);
                end
            end
            send_byte(ld_buf[i][7:0], jitter);
            ref_mem[i]   = ld_buf[i];
            ref_known[i] = 1'b1;
        end
        checks++;
        if (load_done !== 1'b1 || cpu_rst !== 1'b0 || in_ready !== 1'b0 || load_err !== 1'b0) begin
            failures++;
            $display("FAIL done_flags n=%0d: done=%b cpu_rst=%b ready=%b err=%b required 1/0/0/0",
                     n, load_done, cpu_rst, in_ready, load_err);
        end
    endtask

    task automatic read_check(input int a, input string name);
        MAR   = 6'(a);
        RAMWr = 1'b0;
        step();
        if (ref_known[a]) begin
            checks++;
            if (MDROut !== ref_mem[a]) begin
                failures++;
                $display("FAIL %s addr=%0d: MDROut=%h required %h", name, a, MDROut, ref_mem[a]);
            end
        end
    endtask

    task automatic check_all_mem(input string name);
        for (int a = 0; a < 64; a++) read_check(a, name);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        RAMWr    = 1'b0;
        step();
        checks++;
        if (cpu_rst !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0 ||
            in_ready !== 1'b0 || MDROut !== 10'h000) begin
            failures++;
            $display("FAIL reset_state: cpu_rst=%b done=%b err=%b ready=%b MDROut=%h required 1/0/0/0/000",
                     cpu_rst, load_done, load_err, in_ready, MDROut);
        end
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || cpu_rst !== 1'b1) begin
            failures++;
            $display("FAIL hdr_ready: in_ready=%b cpu_rst=%b required 1/1", in_ready, cpu_rst);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_load_basic();
        ld_buf[0] = 10'h3FF;
        ld_buf[1] = 10'h001;
        ld_buf[2] = 10'h155;
        load_prog(3, 1'b0);
        check_all_mem("basic_mem");
        in_valid = 1'b1;
        in_data  = 8'h02;
        repeat (3) begin
            step();
            checks++;
            if (in_ready !== 1'b0 || load_done !== 1'b1 || cpu_rst !== 1'b0) begin
                failures++;
                $display("FAIL run_hold: ready=%b done=%b cpu_rst=%b required 0/1/0",
                         in_ready, load_done, cpu_rst);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_bad_header(input logic [7:0] hdr);
        do_reset();
        send_byte(hdr, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (load_err !== 1'b1 || in_ready !== 1'b0 || cpu_rst !== 1'b1 || load_done !== 1'b0) begin
                failures++;
                $display("FAIL bad_hdr %h cyc %0d: err=%b ready=%b cpu_rst=%b done=%b required 1/0/1/0",
                         hdr, k, load_err, in_ready, cpu_rst, load_done);
            end
            in_valid = 1'b1;
            in_data  = 8'h03;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_bad_hi();
        logic [9:0] w0;
        do_reset();
        w0 = 10'($urandom);
        send_byte(8'd3, 1'b0);
        send_byte({6'b0, w0[9:8]}, 1'b0);
        send_byte(w0[7:0], 1'b0);
        ref_mem[0] = w0;
        ref_known[0] = 1'b1;
        send_byte(8'h04, 1'b0);
        checks++;
        if (load_err !== 1'b1 || in_ready !== 1'b0 || cpu_rst !== 1'b1) begin
            failures++;
            $display("FAIL bad_hi: err=%b ready=%b cpu_rst=%b required 1/0/1", load_err, in_ready, cpu_rst);
        end
        read_check(0, "bad_hi_word1");
        read_check(1, "bad_hi_word2_untouched");
    endtask

    task automatic test_full_load();
        do_reset();
        for (int i = 0; i < 64; i++) ld_buf[i] = 10'($urandom);
        ld_buf[5] = 10'h0F0;
        load_prog(64, 1'b1);
        check_all_mem("full_mem");
    endtask

    task automatic test_run_write();
        logic [9:0] old;
        old   = ref_mem[5];
        MAR   = 6'd5;
        RAMWr = 1'b1;
        MDRIn = 10'h2AA;
        step();
        checks++;
        if (MDROut !== old) begin
            failures++;
            $display("FAIL run_write_readfirst: MDROut=%h required %h", MDROut, old);
        end
        ref_mem[5] = 10'h2AA;
        RAMWr = 1'b0;
        step();
        checks++;
        if (MDROut !== 10'h2AA) begin
            failures++;
            $display("FAIL run_write_new: MDROut=%h required 2aa", MDROut);
        end
    endtask

    task automatic test_run_random();
        logic [9:0] exp;
        for (int k = 0; k < 60; k++) begin
            core_noise();
            exp = ref_mem[MAR];
            if (RAMWr) ref_mem[MAR] = MDRIn;
            step();
            checks++;
            if (MDROut !== exp) begin
                failures++;
                $display("FAIL run_random k=%0d: MDROut=%h required %h", k, MDROut, exp);
            end
        end
        RAMWr = 1'b0;
    endtask

    task automatic test_reset_midload();
        logic [9:0] w0, w1, w2;
        do_reset();
        w0 = 10'($urandom);
        w1 = 10'($urandom);
        w2 = ~ref_mem[2];
        send_byte(8'd5, 1'b0);
        send_byte({6'b0, w0[9:8]}, 1'b0);
        send_byte(w0[7:0], 1'b0);
        send_byte({6'b0, w1[9:8]}, 1'b0);
        send_byte(w1[7:0], 1'b0);
        send_byte({6'b0, w2[9:8]}, 1'b0);
        ref_mem[0] = w0;
        ref_mem[1] = w1;
        in_valid = 1'b1;
        in_data  = w2[7:0];
        rst      = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (cpu_rst !== 1'b1 || load_done !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL midload_reset: cpu_rst=%b done=%b ready=%b required 1/0/0", cpu_rst, load_done, in_ready);
        end
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midload_hdr: in_ready=%b required 1", in_ready);
        end
        read_check(0, "midload_w0");
        read_check(1, "midload_w1");
        read_check(2, "midload_w2_untouched");
        for (int i = 0; i < 4; i++) ld_buf[i] = 10'($urandom);
        load_prog(4, 1'b1);
        check_all_mem("reload_mem");
    endtask

    task automatic test_random_loads();
        int n;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            n = $urandom_range(1, 64);
            for (int i = 0; i < n; i++) ld_buf[i] = 10'($urandom);
            load_prog(n, 1'b1);
            check_all_mem("rand_load_mem");
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        MAR      = 6'd0;
        RAMWr    = 1'b0;
        MDRIn    = 10'h000;
        for (int a = 0; a < 64; a++) begin
            ref_mem[a]   = 10'h000;
            ref_known[a] = 1'b0;
        end
        test_reset();
        test_load_basic();
        test_bad_header(8'd0);
        test_bad_header(8'd65);
        test_bad_hi();
        test_full_load();
        test_run_write();
        test_run_random();
        test_reset_midload();
        test_random_loads();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fbcpu_boot_loader.md
Name: fbcpu_boot_loader

Overview:
- Upstream partner of the FBCPU core: owns the 64 x 10-bit program/data RAM.
- Fills the RAM from an external byte stream (valid/ready), holding the core in reset while it loads.
- After loading, it serves the core's MAR/RAMWr/MDRIn/MDROut port directly.
- Contains the RAM, so the core connects to this block only.

Parameters:
- ADDRESS_WIDTH, 6, RAM address width; depth = 2**ADDRESS_WIDTH = 64.
- DATA_WIDTH, 10, RAM word width; must be 9..16.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  stream byte valid.
- in_ready  output  1  loader can accept a byte.
- in_data  input  8  stream byte.
- MAR  input  ADDRESS_WIDTH  core address.
- RAMWr  input  1  core write strobe.
- MDRIn  input  DATA_WIDTH  core write data.
- MDROut  output  DATA_WIDTH  RAM read data to core.
- cpu_rst  output  1  reset to the core; high while not running.
- load_done  output  1  program loaded, core running.
- load_err  output  1  sticky stream-format error.

Behaviour:
- A byte transfers only on a cycle where in_valid && in_ready.
- Stream format:
  - Header byte N: the word count, legal 1..64.
  - Then N word pairs, each sent as HI then LO.
  - HI byte: bits[1:0] = word[9:8]; bits[7:2] must be 0.
  - LO byte: bits[7:0] = word[7:0].
- Words are written to addresses 0..N-1 in order. Addresses N..63 are untouched.
- FSM states and transitions:
  - HDR: in_ready=1. On transfer: N in 1..64 -> latch count, addr=0, go to HI. Otherwise -> ERR.
  - HI: in_ready=1. On transfer: bits[7:2]!=0 -> ERR. Else latch bits[1:0] into hi_reg, go to LO.
  - LO: in_ready=1. On transfer, RAM writes {hi_reg, in_data} at addr on this same edge, then addr+1.
    - If this was word N-1 -> RUN, else -> HI.
  - RUN: in_ready=0, cpu_rst=0, load_done=1. RAM write port is driven by the core: mem[MAR] <= MDRIn when RAMWr=1.
  - ERR: in_ready=0, load_err=1, cpu_rst=1. Held until rst.
- Outputs are registered, decoded from state:
  - cpu_rst=1 in every state except RUN.
  - load_done deasserts on the same edge cpu_rst asserts.
- Latency: the core leaves reset on the first edge after the last LO byte is accepted. load_done and cpu_rst change together.
- Read path:
  - Synchronous, one cycle: MDROut <= mem[MAR] every edge, in every state.
  - This matches the core: it drives MAR in fetch state 0 and samples MDROut in state 1.
- Write-then-read of the same address on one edge: MDROut returns the OLD word (read-first).
- During load, core inputs MAR/RAMWr/MDRIn are ignored for writes. cpu_rst=1 keeps them at 0 anyway.
- Counters:
  - addr is ADDRESS_WIDTH bits; the final increment (63 -> 0 on N=64) is harmless because the FSM leaves LO.
  - The word count is held in 7 bits.
- Reset (any state, including mid-load or RUN):
  - state=HDR, addr=0, hi_reg=0.
  - Outputs: cpu_rst=1, load_done=0, load_err=0, in_ready=0 during the reset cycle, MDROut=0.
  - RAM contents are NOT cleared; a new load overwrites.
- in_valid with in_ready=0 (RUN/ERR): the byte is ignored; there is no back-pressure effect on state.

Decomposition:
- Shared package fbcpu_pkg holds:
  - Loader state enum {HDR, HI, LO, RUN, ERR}.
  - MAX_WORDS = 64 constant.
  - HI-byte reserved-bit mask 8'hFC.
- One sub-module, fbcpu_ram: single port, synchronous read-first read, synchronous write, no reset of the array.
- The loader FSM and port mux stay in fbcpu_boot_loader.

Test Plan:
- Load N=3, words 10'h3FF, 10'h001, 10'h155 -> memory matches at 0..2. load_done=1 and cpu_rst=0 one edge after the 7th byte. in_ready=0 after.
- Header 0 and header 65 (separate runs) -> ERR next edge, load_err=1, in_ready=0, cpu_rst stays 1 until rst.
- HI byte 8'h04 in word 2 -> ERR. Word 1 is already in RAM and word 2 is not written.
- N=64, full load with in_valid toggled randomly -> all 64 words correct, no wrap overwrite of address 0, done after the 129th transferred byte.
- In RUN: RAMWr=1, MAR=6'd5, MDRIn=10'h2AA, then read MAR=5. Same-edge MDROut shows the old value; the next cycle shows 10'h2AA.
- rst asserted in LO mid-load -> next state HDR, cpu_rst=1, load_done=0, RAM words already written still readable. A fresh load completes normally.
